// File: rtl/pipibibs_eeprom.sv
// pipibibs_eeprom: 93C46-compatible 64x16 serial EEPROM responder with host NVRAM load/save port
module pipibibs_eeprom #(
  parameter int PROG_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EEPROM_SCLK,
  input  logic        EEPROM_SCS,
  input  logic        EEPROM_SDI,
  output logic        EEPROM_SDO,
  input  logic [5:0]  HOST_ADDR,
  input  logic [15:0] HOST_DIN,
  input  logic        HOST_WE,
  output logic [15:0] HOST_DOUT,
  output logic        BUSY
);
  localparam int PW = $clog2(PROG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CMD, READ, WDATA, DONE, PROG} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_s, cs_s, sdi_s;
  logic sclk_d, cs, sdi, rise;
  logic [15:0] mem [64];
  logic [6:0] sr;
  logic [7:0] cmd_w;
  logic [3:0] cnt;
  logic [5:0] addr, s_wa;
  logic [15:0] data;
  logic wen, all_w, pend, prog_go, s_we;
  logic [PW-1:0] pcnt;
  assign cs = cs_s[SYNC_STAGES-1];
  assign sdi = sdi_s[SYNC_STAGES-1];
  assign rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign cmd_w = {sr, sdi};
  // Serial program writes: single word (or word 0 of a bulk op) at CS fall, remaining bulk words during PROG
  always_comb begin
    prog_go = state == DONE && !cs && pend && wen;
    s_we = prog_go | (state == PROG && all_w && pcnt < PW'(63));
    s_wa = prog_go ? (all_w ? 6'd0 : addr) : pcnt[5:0] + 6'd1;
  end
  // Synchronizers and the serial protocol state machine
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      sclk_s <= '0;
      cs_s <= '0;
      sdi_s <= '0;
      sclk_d <= 1'b0;
      sr <= '0;
      cnt <= '0;
      addr <= '0;
      data <= '0;
      wen <= 1'b0;
      all_w <= 1'b0;
      pend <= 1'b0;
      pcnt <= '0;
      EEPROM_SDO <= 1'b1;
      BUSY <= 1'b0;
    end else begin
      sclk_s <= (sclk_s << 1) | SYNC_STAGES'(EEPROM_SCLK);
      cs_s <= (cs_s << 1) | SYNC_STAGES'(EEPROM_SCS);
      sdi_s <= (sdi_s << 1) | SYNC_STAGES'(EEPROM_SDI);
      sclk_d <= sclk_s[SYNC_STAGES-1];
      if (state == PROG) begin
        EEPROM_SDO <= ~cs;
        pcnt <= pcnt + 1'b1;
        if (pcnt == PW'(PROG_CYCLES - 1)) begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
      end else if (!cs) begin
        EEPROM_SDO <= 1'b1;
        state <= prog_go ? PROG : IDLE;
        BUSY <= prog_go;
        pcnt <= '0;
      end else begin
        if (state == IDLE) EEPROM_SDO <= 1'b1;
        if (rise) begin
          case (state)
            IDLE: begin
              if (sdi) begin
                state <= CMD;
                cnt <= '0;
              end
            end
            CMD: begin
              sr <= cmd_w[6:0];
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                addr <= cmd_w[5:0];
                cnt <= '0;
                pend <= 1'b0;
                all_w <= 1'b0;
                case (cmd_w[7:6])
                  2'b10: begin
                    state <= READ;
                    data <= mem[cmd_w[5:0]];
                    EEPROM_SDO <= 1'b0;
                  end
                  2'b01: state <= WDATA;
                  2'b11: begin
                    state <= DONE;
                    data <= 16'hFFFF;
                    pend <= 1'b1;
                  end
                  default: begin
                    all_w <= cmd_w[5] ^ cmd_w[4];
                    state <= cmd_w[5:4] == 2'b01 ? WDATA : DONE;
                    pend <= cmd_w[5:4] == 2'b10;
                    data <= 16'hFFFF;
                    if (cmd_w[5] == cmd_w[4]) wen <= cmd_w[5];
                  end
                endcase
              end
            end
            READ: begin
              EEPROM_SDO <= data[15];
              cnt <= cnt + 4'd1;
              data <= cnt == 4'd15 ? mem[addr + 6'd1] : {data[14:0], 1'b0};
              if (cnt == 4'd15) addr <= addr + 6'd1;
            end
            WDATA: begin
              data <= {data[14:0], sdi};
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                state <= DONE;
                pend <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
  // Memory array, not reset; serial program write takes priority over host load
  always_ff @(posedge CLK) begin
    if (HOST_WE) mem[HOST_ADDR] <= HOST_DIN;
    if (s_we) mem[s_wa] <= data;
  end
  // Host save read port with one cycle latency
  always_ff @(posedge CLK) begin
    if (RESET) HOST_DOUT <= '0;
    else HOST_DOUT <= mem[HOST_ADDR];
  end
endmodule
